// File: rtl/sdram_mport_arbiter_if.sv
// rtl/sdram_mport_arbiter_if.sv - bundle of SDRAM controller and requester-port signals
//
// Purpose: groups the controller-side command/response signals and the
// packed per-port request/status signals of the multi-port SDRAM arbiter.
// Ports (signals):
//   sdram_*  : command, data and ack toward the controller; ready/rdy/response
//              coming back from it
//   p_*      : per-port request fields (port i at slice i) and per-port status
// Modports:
//   master : the arbiter's view (drives sdram_* commands and p_* status)
//   slave  : the environment's view (controller model plus requesters)
interface sdram_mport_arbiter_if #(
  parameter int NUM_PORTS = 3
);
  logic                      sdram_cmd_valid;
  logic                      sdram_rd;
  logic                      sdram_wr;
  logic                      sdram_burst;
  logic                      sdram_ack;
  logic [23:0]               sdram_addr_x16;
  logic [15:0]               sdram_wdata;
  logic [1:0]                sdram_wmask;
  logic                      sdram_cmd_ready;
  logic                      sdram_rdy;
  logic                      sdram_resp_valid;
  logic                      sdram_resp_last;
  logic [15:0]               sdram_rdata;

  logic [NUM_PORTS-1:0]      p_cmd_valid;
  logic [NUM_PORTS-1:0]      p_rd;
  logic [NUM_PORTS-1:0]      p_wr;
  logic [NUM_PORTS-1:0]      p_burst;
  logic [NUM_PORTS-1:0]      p_ack;
  logic [24*NUM_PORTS-1:0]   p_addr_x16;
  logic [16*NUM_PORTS-1:0]   p_wdata;
  logic [2*NUM_PORTS-1:0]    p_wmask;
  logic [NUM_PORTS-1:0]      p_cmd_ready;
  logic [NUM_PORTS-1:0]      p_rdy;
  logic [NUM_PORTS-1:0]      p_resp_valid;
  logic [NUM_PORTS-1:0]      p_resp_last;
  logic [15:0]               p_rdata;

  modport master (
    output sdram_cmd_valid, sdram_rd, sdram_wr, sdram_burst, sdram_ack,
    output sdram_addr_x16, sdram_wdata, sdram_wmask,
    input  sdram_cmd_ready, sdram_rdy, sdram_resp_valid, sdram_resp_last, sdram_rdata,
    input  p_cmd_valid, p_rd, p_wr, p_burst, p_ack, p_addr_x16, p_wdata, p_wmask,
    output p_cmd_ready, p_rdy, p_resp_valid, p_resp_last, p_rdata
  );

  modport slave (
    input  sdram_cmd_valid, sdram_rd, sdram_wr, sdram_burst, sdram_ack,
    input  sdram_addr_x16, sdram_wdata, sdram_wmask,
    output sdram_cmd_ready, sdram_rdy, sdram_resp_valid, sdram_resp_last, sdram_rdata,
    output p_cmd_valid, p_rd, p_wr, p_burst, p_ack, p_addr_x16, p_wdata, p_wmask,
    input  p_cmd_ready, p_rdy, p_resp_valid, p_resp_last, p_rdata
  );
endinterface

// File: rtl/sdram_mport_arbiter.sv
// rtl/sdram_mport_arbiter.sv - multi-port SDRAM command arbiter with port-0 priority
//
// Purpose: shares one SDRAM controller between NUM_PORTS requesters. In IDLE a
// winner is picked combinationally (port 0 first when enabled, limited by a
// starvation counter; otherwise round-robin) and its command is presented to
// the controller. Once accepted the winner owns the controller until it acks.
// Ports:
//   clk_i   : clock
//   rst_ni  : asynchronous active-low reset; also forces every output to 0
//   bus     : sdram_mport_arbiter_if.master (controller and per-port signals)
//   grant_o : one-hot current owner, zero when idle
module sdram_mport_arbiter #(
  parameter int NUM_PORTS     = 3,
  parameter int HIPRI_PORT0   = 1,
  parameter int MAX_HIPRI_RUN = 4,
  parameter int WAIT_CYCLES   = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  sdram_mport_arbiter_if.master bus,
  output logic [NUM_PORTS-1:0]  grant_o
);

  localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic {IDLE, BUSY} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [1:0]       wait_cnt_q, wait_cnt_d;
  logic [3:0]       hipri_run_q, hipri_run_d;

  logic             win_found;
  logic [IDX_W-1:0] win_idx;
  logic [IDX_W-1:0] sel_idx;
  logic [IDX_W-1:0] cand;
  logic             others_valid;
  logic             accept;
  logic             cmd_live;
  int               pos;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      rr_ptr_q    <= IDX_W'(NUM_PORTS - 1);
      wait_cnt_q  <= '0;
      hipri_run_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      wait_cnt_q  <= wait_cnt_d;
      hipri_run_q <= hipri_run_d;
    end
  end

  always_comb begin
    win_found    = 1'b0;
    win_idx      = '0;
    cand         = '0;
    pos          = 0;
    others_valid = |bus.p_cmd_valid[NUM_PORTS-1:1];

    if ((HIPRI_PORT0 != 0) && bus.p_cmd_valid[0] &&
        ((hipri_run_q < 4'(MAX_HIPRI_RUN)) || !others_valid)) begin
      win_found = 1'b1;
      win_idx   = '0;
    end else begin
      // Port 0 is skipped by the round-robin search when it has priority:
      // here it either is not requesting or has used up its run, so letting
      // the search land on it would defeat the starvation limit.
      for (int k = 1; k <= NUM_PORTS; k++) begin
        pos  = (int'(rr_ptr_q) + k) % NUM_PORTS;
        cand = IDX_W'(pos);
        if (!win_found && bus.p_cmd_valid[cand] && !((HIPRI_PORT0 != 0) && (pos == 0))) begin
          win_found = 1'b1;
          win_idx   = cand;
        end
      end
    end
  end

  assign sel_idx  = (state_q == IDLE) ? win_idx : owner_q;
  assign cmd_live = (state_q == BUSY) || win_found;
  assign accept   = (state_q == IDLE) && win_found && bus.sdram_cmd_ready;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    wait_cnt_d  = wait_cnt_q;
    hipri_run_d = hipri_run_q;
    case (state_q)
      IDLE: begin
        if (!bus.p_cmd_valid[0]) hipri_run_d = '0;
        if (accept) begin
          state_d    = BUSY;
          owner_d    = win_idx;
          wait_cnt_d = 2'(WAIT_CYCLES);
          if (win_idx == '0) begin
            hipri_run_d = (hipri_run_q == 4'hF) ? hipri_run_q : hipri_run_q + 4'd1;
          end else begin
            hipri_run_d = '0;
          end
          if ((win_idx != '0) || (HIPRI_PORT0 == 0)) rr_ptr_d = win_idx;
        end
      end
      BUSY: begin
        if (wait_cnt_q != 2'd0) wait_cnt_d = wait_cnt_q - 2'd1;
        if (bus.p_ack[owner_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are gated by rst_ni so they drop to 0 the moment reset asserts,
  // independent of the clock and of whatever the ports are driving.
  always_comb begin
    bus.sdram_cmd_valid = 1'b0;
    bus.sdram_rd        = 1'b0;
    bus.sdram_wr        = 1'b0;
    bus.sdram_burst     = 1'b0;
    bus.sdram_ack       = 1'b0;
    bus.sdram_addr_x16  = '0;
    bus.sdram_wdata     = '0;
    bus.sdram_wmask     = '0;
    bus.p_cmd_ready     = '0;
    bus.p_rdy           = '0;
    bus.p_resp_valid    = '0;
    bus.p_resp_last     = '0;
    bus.p_rdata         = '0;
    grant_o             = '0;
    if (rst_ni) begin
      bus.p_rdata         = bus.sdram_rdata;
      bus.sdram_cmd_valid = (state_q == IDLE) && (|bus.p_cmd_valid);
      bus.sdram_ack       = (state_q == BUSY) && bus.p_ack[owner_q];
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (cmd_live && (sel_idx == IDX_W'(i))) begin
          bus.sdram_rd       = bus.p_rd[i];
          bus.sdram_wr       = bus.p_wr[i];
          bus.sdram_burst    = bus.p_burst[i];
          bus.sdram_addr_x16 = bus.p_addr_x16[i*24 +: 24];
          bus.sdram_wdata    = bus.p_wdata[i*16 +: 16];
          bus.sdram_wmask    = bus.p_wmask[i*2 +: 2];
        end
        if ((state_q == IDLE) && win_found && (win_idx == IDX_W'(i))) begin
          bus.p_cmd_ready[i] = bus.sdram_cmd_ready;
        end
        if ((state_q == BUSY) && (owner_q == IDX_W'(i))) begin
          grant_o[i]          = 1'b1;
          bus.p_rdy[i]        = (wait_cnt_q == 2'd0) && bus.sdram_rdy;
          bus.p_resp_valid[i] = bus.sdram_resp_valid;
          bus.p_resp_last[i]  = bus.sdram_resp_last;
        end
      end
    end
  end

endmodule

// File: tb/tb_sdram_mport_arbiter.sv
// tb/tb_sdram_mport_arbiter.sv - directed self-checking bench for sdram_mport_arbiter
module tb_sdram_mport_arbiter;
  localparam int NP = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  sdram_mport_arbiter_if #(.NUM_PORTS(NP)) hp ();
  sdram_mport_arbiter_if #(.NUM_PORTS(NP)) rr ();
  logic [NP-1:0] grant_hp;
  logic [NP-1:0] grant_rr;

  sdram_mport_arbiter #(
    .NUM_PORTS(NP), .HIPRI_PORT0(1), .MAX_HIPRI_RUN(4), .WAIT_CYCLES(2)
  ) u_dut_hp (
    .clk_i(clk), .rst_ni(rst_n), .bus(hp), .grant_o(grant_hp)
  );

  sdram_mport_arbiter #(
    .NUM_PORTS(NP), .HIPRI_PORT0(0), .MAX_HIPRI_RUN(4), .WAIT_CYCLES(2)
  ) u_dut_rr (
    .clk_i(clk), .rst_ni(rst_n), .bus(rr), .grant_o(grant_rr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  initial begin
    hp.sdram_cmd_ready = 1'b1;  hp.sdram_rdy = 1'b1;
    hp.sdram_resp_valid = 1'b0; hp.sdram_resp_last = 1'b0;
    hp.sdram_rdata = 16'hBEEF;
    hp.p_cmd_valid = 3'b111;    hp.p_ack = 3'b000;
    hp.p_rd = 3'b010;           hp.p_wr = 3'b101;   hp.p_burst = 3'b011;
    hp.p_addr_x16 = {24'h00C002, 24'h00B001, 24'h00A000};
    hp.p_wdata = {16'h9ABC, 16'h5678, 16'h1234};
    hp.p_wmask = {2'b11, 2'b10, 2'b01};

    rr.sdram_cmd_ready = 1'b0;  rr.sdram_rdy = 1'b0;
    rr.sdram_resp_valid = 1'b0; rr.sdram_resp_last = 1'b0;
    rr.sdram_rdata = 16'h0000;
    rr.p_cmd_valid = 3'b000;    rr.p_ack = 3'b000;
    rr.p_rd = 3'b000;           rr.p_wr = 3'b000;   rr.p_burst = 3'b000;
    rr.p_addr_x16 = {24'h000300, 24'h000200, 24'h000100};
    rr.p_wdata = '0;            rr.p_wmask = '0;

    // Outputs held at 0 during reset even with every port requesting
    repeat (2) @(negedge clk);
    #1;
    check("rst_cmd_valid", 32'(hp.sdram_cmd_valid), 0);
    check("rst_cmd_ready", 32'(hp.p_cmd_ready), 0);
    check("rst_grant", 32'(grant_hp), 0);
    check("rst_addr", 32'(hp.sdram_addr_x16), 0);
    check("rst_rdata", 32'(hp.p_rdata), 0);

    // Release with nothing pending: idle outputs all 0, no grant
    hp.p_cmd_valid = 3'b000;
    rst_n = 1'b1;
    @(negedge clk); #1;
    check("post_rst_grant", 32'(grant_hp), 0);
    check("idle_cmd_valid", 32'(hp.sdram_cmd_valid), 0);
    check("idle_wr", 32'(hp.sdram_wr), 0);
    check("idle_addr", 32'(hp.sdram_addr_x16), 0);
    check("idle_rdata_bcast", 32'(hp.p_rdata), 32'h0000BEEF);

    // All three request together: port 0 wins
    hp.p_cmd_valid = 3'b111; #1;
    check("p0_cmd_ready", 32'(hp.p_cmd_ready), 32'b001);
    check("p0_cmd_valid", 32'(hp.sdram_cmd_valid), 1);
    check("p0_addr", 32'(hp.sdram_addr_x16), 32'h00A000);
    check("p0_wr", 32'(hp.sdram_wr), 1);
    check("p0_wdata", 32'(hp.sdram_wdata), 32'h1234);
    check("p0_wmask", 32'(hp.sdram_wmask), 32'b01);

    @(posedge clk); #1;
    hp.p_cmd_valid = 3'b110; #1;
    check("p0_grant", 32'(grant_hp), 32'b001);
    check("busy_cmd_valid", 32'(hp.sdram_cmd_valid), 0);
    check("busy_cmd_ready", 32'(hp.p_cmd_ready), 0);
    check("busy_owner_addr", 32'(hp.sdram_addr_x16), 32'h00A000);
    check("rdy_mask_c1", 32'(hp.p_rdy), 0);
    @(posedge clk); #2;
    check("rdy_mask_c2", 32'(hp.p_rdy), 0);
    @(posedge clk); #2;
    check("rdy_open_c3", 32'(hp.p_rdy), 32'b001);
    hp.p_ack = 3'b001; #1;
    check("p0_sdram_ack", 32'(hp.sdram_ack), 1);

    // Back in IDLE: port 1 is next after rr_ptr=2
    @(posedge clk); #1;
    hp.p_ack = 3'b000; #1;
    check("p1_cmd_ready", 32'(hp.p_cmd_ready), 32'b010);
    check("p1_idle_grant", 32'(grant_hp), 0);
    check("p1_addr", 32'(hp.sdram_addr_x16), 32'h00B001);
    check("p1_rd", 32'(hp.sdram_rd), 1);

    // Isolation: non-owner ack ignored, response routed to owner only
    @(posedge clk); #1;
    hp.p_cmd_valid = 3'b100;
    hp.p_ack = 3'b100;
    hp.sdram_resp_valid = 1'b1; hp.sdram_resp_last = 1'b1;
    hp.sdram_rdata = 16'h5A5A; #1;
    check("iso_grant", 32'(grant_hp), 32'b010);
    check("iso_sdram_ack", 32'(hp.sdram_ack), 0);
    check("iso_resp_valid", 32'(hp.p_resp_valid), 32'b010);
    check("iso_resp_last", 32'(hp.p_resp_last), 32'b010);
    check("iso_rdata", 32'(hp.p_rdata), 32'h5A5A);
    @(posedge clk); #1;
    hp.p_ack = 3'b000;
    hp.sdram_resp_valid = 1'b0; hp.sdram_resp_last = 1'b0; #1;
    check("iso_no_release", 32'(grant_hp), 32'b010);
    check("iso_resp_clear", 32'(hp.p_resp_valid), 0);
    hp.p_ack = 3'b010; #1;
    check("p1_sdram_ack", 32'(hp.sdram_ack), 1);

    @(posedge clk); #1;
    hp.p_ack = 3'b000; #1;
    check("p2_cmd_ready", 32'(hp.p_cmd_ready), 32'b100);

    // Async reset mid-BUSY with the owner acking
    @(posedge clk); #1;
    hp.p_cmd_valid = 3'b000;
    hp.p_ack = 3'b100; #1;
    check("p2_grant", 32'(grant_hp), 32'b100);
    check("p2_sdram_ack", 32'(hp.sdram_ack), 1);
    check("p2_wr", 32'(hp.sdram_wr), 1);
    #1 rst_n = 1'b0;
    #1;
    check("arst_grant", 32'(grant_hp), 0);
    check("arst_ack", 32'(hp.sdram_ack), 0);
    check("arst_wr", 32'(hp.sdram_wr), 0);
    check("arst_addr", 32'(hp.sdram_addr_x16), 0);
    hp.p_ack = 3'b000;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("arst_release_grant", 32'(grant_hp), 0);
    check("arst_release_valid", 32'(hp.sdram_cmd_valid), 0);

    // Starvation limit: ports 0 and 2 always valid, every grant acked at once
    hp.p_cmd_valid = 3'b101;
    hp.p_ack = 3'b111; #1;
    for (int g = 0; g < 10; g++) begin
      logic [2:0] exp_g;
      exp_g = ((g % 5) == 4) ? 3'b100 : 3'b001;
      check($sformatf("starve_ready_%0d", g), 32'(hp.p_cmd_ready), 32'(exp_g));
      @(posedge clk); #2;
      check($sformatf("starve_grant_%0d", g), 32'(grant_hp), 32'(exp_g));
      @(posedge clk); #2;
    end
    hp.p_cmd_valid = 3'b000;
    hp.p_ack = 3'b000;

    // Pure round-robin: ports 1 and 2 always valid, ack on 3rd BUSY cycle
    rr.p_cmd_valid = 3'b110;
    rr.sdram_cmd_ready = 1'b1;
    rr.sdram_rdy = 1'b1; #1;
    for (int g = 0; g < 4; g++) begin
      logic [2:0] exp_r;
      exp_r = ((g % 2) == 0) ? 3'b010 : 3'b100;
      check($sformatf("rr_ready_%0d", g), 32'(rr.p_cmd_ready), 32'(exp_r));
      @(posedge clk); #2;
      check($sformatf("rr_grant_%0d", g), 32'(grant_rr), 32'(exp_r));
      @(posedge clk); #2;
      check($sformatf("rr_rdy_masked_%0d", g), 32'(rr.p_rdy), 0);
      @(posedge clk); #1;
      rr.p_ack = 3'b110; #1;
      check($sformatf("rr_rdy_open_%0d", g), 32'(rr.p_rdy), 32'(exp_r));
      check($sformatf("rr_ack_%0d", g), 32'(rr.sdram_ack), 1);
      @(posedge clk); #1;
      rr.p_ack = 3'b000; #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/sdram_mport_arbiter.md
SDRAM_MPORT_ARBITER -- requirements
Module: sdram_mport_arbiter

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 3: number of requester ports, range 2..8.
REQ-002 SHALL have parameter HIPRI_PORT0, default 1: port 0 gets fixed top priority when 1; pure round-robin when 0.
REQ-003 SHALL have parameter MAX_HIPRI_RUN, default 4: consecutive port-0 grants allowed while another port is pending; range 1..15.
REQ-004 SHALL have parameter WAIT_CYCLES, default 2: cycles after grant during which sdram_rdy is masked; range 0..3.
REQ-005 SHALL have one clock; reset is asynchronous and active-low.
REQ-006 SHALL have ports (name dir width meaning):
- clk_i in 1: clock
- rst_ni in 1: async reset, active low
- sdram_cmd_valid / sdram_rd / sdram_wr / sdram_burst / sdram_ack out 1: controller command and ack
- sdram_addr_x16 out 24; sdram_wdata out 16; sdram_wmask out 2: controller command data
- sdram_cmd_ready / sdram_rdy / sdram_resp_valid / sdram_resp_last in 1; sdram_rdata in 16: controller status and response
- p_cmd_valid / p_rd / p_wr / p_burst / p_ack in NUM_PORTS: per-port request and ack
- p_addr_x16 in 24*NUM_PORTS; p_wdata in 16*NUM_PORTS; p_wmask in 2*NUM_PORTS: packed per-port fields, port i at slice i
- p_cmd_ready / p_rdy / p_resp_valid / p_resp_last out NUM_PORTS: per-port status
- p_rdata out 16: shared read data
- grant_o out NUM_PORTS: one-hot current owner, zero when idle

Function
REQ-007 SHALL have a two-state FSM: IDLE, BUSY; registers owner, rr_ptr, wait_cnt, hipri_run.
REQ-008 SHALL compute winner in IDLE combinationally:
- port 0 wins if HIPRI_PORT0=1, p_cmd_valid[0]=1, and (hipri_run < MAX_HIPRI_RUN or no other port valid)
- otherwise the first valid port searching upward from rr_ptr+1, modulo NUM_PORTS
REQ-009 SHALL drive sdram_cmd_valid = IDLE and any p_cmd_valid.
REQ-010 SHALL drive p_cmd_ready[i] = IDLE and sdram_cmd_ready and winner==i; all other bits 0.
REQ-011 SHALL mux the winner's rd/wr/addr/wdata/wmask/burst to the sdram_* outputs in the same cycle in IDLE, and the owner's in BUSY.
REQ-012 SHALL, on acceptance (p_cmd_ready[i] and p_cmd_valid[i]), take the following actions, all visible next cycle:
- owner<=i, state<=BUSY, wait_cnt<=WAIT_CYCLES
- hipri_run<=hipri_run+1 (saturating) if i==0, else 0
- rr_ptr<=i if i!=0 or HIPRI_PORT0=0
REQ-013 SHALL decrement wait_cnt by 1 each BUSY cycle until 0.
REQ-014 SHALL drive p_rdy[owner] = BUSY and wait_cnt==0 and sdram_rdy.
REQ-015 SHALL route sdram_resp_valid and sdram_resp_last only to the owner's bits.
REQ-016 SHALL broadcast sdram_rdata to p_rdata.
REQ-017 SHALL drive sdram_ack = BUSY and p_ack[owner].
REQ-018 SHALL ignore p_ack from non-owners and in IDLE.
REQ-019 SHALL, in BUSY, on p_ack[owner] go to IDLE next cycle; a new grant is possible that next cycle, not the ack cycle.
REQ-020 SHALL drive all sdram_* command outputs to 0 in IDLE with no valid request, never X.
REQ-021 SHALL drive p_cmd_ready, p_rdy, p_resp_valid and grant_o to 0 in the same idle condition.
REQ-022 SHALL reset hipri_run to 0 when port 0 is not valid in IDLE.

Reset
REQ-023 SHALL, while rst_ni=0, force asynchronously:
- state=IDLE, owner=0, rr_ptr=NUM_PORTS-1, wait_cnt=0, hipri_run=0
- all outputs 0
REQ-024 SHALL abandon an in-flight transaction on reset mid-BUSY, with no ack issued.
REQ-025 SHALL grant nothing in the first cycle after rst_ni rises if no port is valid.

Verification
REQ-026 SHALL cover, NUM_PORTS=3, HIPRI_PORT0=1: ports 0,1,2 valid same cycle, sdram_cmd_ready=1 -> p_cmd_ready=001, grant_o=001 next cycle.
REQ-027 SHALL cover, HIPRI_PORT0=0: ports 1,2 continuously valid, each acked 3 cycles after grant -> grants alternate 1,2,1,2.
REQ-028 SHALL cover starvation limit, MAX_HIPRI_RUN=4: port 0 and port 2 continuously valid -> 4 port-0 grants, then 1 port-2 grant, repeating.
REQ-029 SHALL cover rdy masking, WAIT_CYCLES=2: sdram_rdy=1 throughout -> p_rdy[owner] 0 for 2 BUSY cycles, 1 on the third.
REQ-030 SHALL cover isolation: p_ack[2] pulsed while port 1 owns -> no release, sdram_ack=0; resp_valid seen on port 1 only.
REQ-031 SHALL cover async reset: rst_ni low mid-BUSY between clock edges -> all outputs 0 before the next edge; grant_o=0 after release.
